// File: rtl/qlearn_step_ctrl.sv
// Q-learning step sequencer: walks one episode from a start state to an end
// state, serialising all Q / Qmax table accesses and handing operands to an
// external arithmetic pipeline.
module qlearn_step_ctrl #(
  parameter int unsigned S_W       = 6,
  parameter int unsigned A_W       = 2,
  parameter int unsigned D_W       = 8,
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [S_W-1:0]       i_start_state,
  input  logic [S_W-1:0]       i_end_state,
  input  logic [A_W-1:0]       i_action,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [S_W-1:0]       o_state,
  output logic [STEP_W-1:0]    o_step_cnt,
  output logic [S_W+A_W-1:0]   o_q_addr,
  output logic                 o_q_we,
  output logic [D_W-1:0]       o_q_wdata,
  input  logic [D_W-1:0]       i_q_rdata,
  output logic [S_W+A_W-1:0]   o_sa_addr,
  input  logic [D_W-1:0]       i_r_rdata,
  input  logic [S_W-1:0]       i_ns_rdata,
  output logic [S_W-1:0]       o_qm_addr,
  output logic                 o_qm_we,
  output logic [D_W-1:0]       o_qm_wdata,
  input  logic [D_W-1:0]       i_qm_rdata,
  output logic                 o_calc_valid,
  output logic [D_W-1:0]       o_op_q,
  output logic [D_W-1:0]       o_op_r,
  output logic [D_W-1:0]       o_op_qmax,
  input  logic                 i_calc_done,
  input  logic [D_W-1:0]       i_sum
);

  typedef enum logic [3:0] {
    IDLE, RD_Q, WAIT_Q, RD_QM, WAIT_QM, CALC, WR_Q, WR_QM, ADV, FIN
  } state_t;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_t              state;
  state_t              state_next;
  logic [S_W-1:0]      s;
  logic [S_W-1:0]      sp;
  logic [S_W-1:0]      end_s;
  logic [A_W-1:0]      a;
  logic [D_W-1:0]      q;
  logic [D_W-1:0]      r;
  logic [D_W-1:0]      qmax_s;
  logic [D_W-1:0]      qmax_ns;
  logic [D_W-1:0]      sum;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_inc;
  logic [S_W-1:0]      entry_s;
  logic                last_step;
  logic                abort_now;

  assign step_inc  = step_cnt + STEP_W'(1);
  assign last_step = (sp == end_s) || (step_inc == STEP_LIMIT);
  assign abort_now = i_abort && (state != IDLE);
  // State that the next RD_Q will operate on: start state from IDLE, s' from ADV.
  assign entry_s   = (state == IDLE) ? i_start_state : sp;

  assign o_state    = s;
  assign o_step_cnt = step_cnt;
  assign o_op_q     = q;
  assign o_op_r     = r;
  assign o_op_qmax  = qmax_ns;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (i_start) state_next = (i_start_state == i_end_state) ? FIN : RD_Q;
      RD_Q:    state_next = WAIT_Q;
      WAIT_Q:  state_next = RD_QM;
      RD_QM:   state_next = WAIT_QM;
      WAIT_QM: state_next = CALC;
      CALC:    if (i_calc_done) state_next = WR_Q;
      WR_Q:    state_next = (sum > qmax_s) ? WR_QM : ADV;
      WR_QM:   state_next = ADV;
      ADV:     state_next = last_step ? FIN : RD_Q;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_now) state_next = IDLE;
  end

  // Datapath: episode registers, operand capture and registered table addresses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s         <= '0;
      sp        <= '0;
      end_s     <= '0;
      a         <= '0;
      q         <= '0;
      r         <= '0;
      qmax_s    <= '0;
      qmax_ns   <= '0;
      sum       <= '0;
      step_cnt  <= '0;
      o_q_addr  <= '0;
      o_sa_addr <= '0;
      o_qm_addr <= '0;
    end else if (!abort_now) begin
      // The action is captured on the edge entering RD_Q so that the registered
      // Q / Qmax addresses are already presented during RD_Q and the 1-cycle
      // BRAM data lands in WAIT_Q.
      if (state_next == RD_Q && state != RD_Q) begin
        a         <= i_action;
        o_q_addr  <= {entry_s, i_action};
        o_sa_addr <= {entry_s, i_action};
        o_qm_addr <= entry_s;
      end
      unique case (state)
        IDLE: begin
          if (i_start) begin
            s        <= i_start_state;
            end_s    <= i_end_state;
            step_cnt <= '0;
          end
        end
        WAIT_Q: begin
          q         <= i_q_rdata;
          qmax_s    <= i_qm_rdata;
          r         <= i_r_rdata;
          sp        <= i_ns_rdata;
          o_qm_addr <= i_ns_rdata;
        end
        WAIT_QM: qmax_ns <= i_qm_rdata;
        CALC: begin
          if (i_calc_done) begin
            sum      <= i_sum;
            o_q_addr <= {s, a};
          end
        end
        WR_Q: if (sum > qmax_s) o_qm_addr <= s;
        ADV: begin
          s        <= sp;
          step_cnt <= step_inc;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; write enables are gated by abort in the same cycle.
  always_comb begin
    o_busy       = (state != IDLE);
    o_done       = (state == FIN);
    o_calc_valid = (state == CALC);
    o_q_we       = (state == WR_Q)  && !i_abort;
    o_qm_we      = (state == WR_QM) && !i_abort;
    o_q_wdata    = sum;
    o_qm_wdata   = sum;
  end

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Self-checking bench for qlearn_step_ctrl: BRAM/ROM models, a pipeline
// responder and an episode-level reference model of the Q-learning walk.
module tb_qlearn_step_ctrl;

  localparam int MAXS = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort, calc_done;
  logic [5:0]  start_state, end_state;
  logic [1:0]  action;
  logic [7:0]  sum;
  logic        busy, done, q_we, qm_we, calc_valid;
  logic [5:0]  state_o, qm_addr, ns_rdata;
  logic [15:0] step_cnt;
  logic [7:0]  q_addr, sa_addr, q_wdata, q_rdata, r_rdata, qm_wdata, qm_rdata;
  logic [7:0]  op_q, op_r, op_qmax;

  logic [7:0]  q_mem  [256];
  logic [7:0]  qm_mem [64];
  logic [7:0]  ref_q  [256];
  logic [7:0]  ref_qm [64];
  logic [7:0]  r_rom  [256];
  logic [5:0]  ns_rom [256];
  logic        load_mem;

  int          n_cmp = 0;
  int          n_err = 0;

  int          p_n;
  logic [5:0]  p_s    [MAXS];
  logic [1:0]  p_a    [MAXS];
  logic [7:0]  p_q    [MAXS];
  logic [7:0]  p_r    [MAXS];
  logic [7:0]  p_qmax [MAXS];
  logic [7:0]  p_sum  [MAXS];
  bit          p_wqm  [MAXS];
  logic [5:0]  p_final;

  always #5 clk = ~clk;

  qlearn_step_ctrl #(.MAX_STEPS(MAXS)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_state(start_state),
    .i_end_state(end_state), .i_action(action), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_state(state_o), .o_step_cnt(step_cnt),
    .o_q_addr(q_addr), .o_q_we(q_we), .o_q_wdata(q_wdata), .i_q_rdata(q_rdata),
    .o_sa_addr(sa_addr), .i_r_rdata(r_rdata), .i_ns_rdata(ns_rdata),
    .o_qm_addr(qm_addr), .o_qm_we(qm_we), .o_qm_wdata(qm_wdata), .i_qm_rdata(qm_rdata),
    .o_calc_valid(calc_valid), .o_op_q(op_q), .o_op_r(op_r), .o_op_qmax(op_qmax),
    .i_calc_done(calc_done), .i_sum(sum)
  );

  // Single-port 1-cycle BRAMs; load_mem copies the reference tables in.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) q_mem[i] <= ref_q[i];
      for (int i = 0; i < 64; i++)  qm_mem[i] <= ref_qm[i];
    end else begin
      if (q_we)  q_mem[q_addr]   <= q_wdata;
      if (qm_we) qm_mem[qm_addr] <= qm_wdata;
    end
    q_rdata  <= q_mem[q_addr];
    qm_rdata <= qm_mem[qm_addr];
  end

  assign r_rdata  = r_rom[sa_addr];
  assign ns_rdata = ns_rom[sa_addr];

  function automatic int mem_diffs();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (q_mem[i] !== ref_q[i]) bad++;
    for (int i = 0; i < 64; i++)  if (qm_mem[i] !== ref_qm[i]) bad++;
    return bad;
  endfunction

  task automatic load_tables();
    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
  endtask

  task automatic init_tables();
    for (int i = 0; i < 256; i++) begin
      ref_q[i]  = 8'($urandom);
      r_rom[i]  = 8'($urandom);
      ns_rom[i] = 6'($urandom);
    end
    for (int i = 0; i < 64; i++) ref_qm[i] = 8'($urandom);
    load_tables();
  endtask

  // Reference walk of one episode: plans every step and applies its updates to ref tables.
  task automatic plan_episode(input logic [5:0] st, input logic [5:0] en,
                              input int forced_sum, input int fixed_act);
    logic [5:0] cur, nxt;
    logic [1:0] act;
    logic [7:0] idx, sv;
    cur = st;
    p_n = 0;
    while (cur != en && p_n < MAXS) begin
      act = (fixed_act >= 0) ? 2'(fixed_act) : 2'($urandom_range(0, 3));
      idx = {cur, act};
      nxt = ns_rom[idx];
      sv  = (forced_sum >= 0) ? 8'(forced_sum) : 8'($urandom);
      p_s[p_n]    = cur;
      p_a[p_n]    = act;
      p_q[p_n]    = ref_q[idx];
      p_r[p_n]    = r_rom[idx];
      p_qmax[p_n] = ref_qm[nxt];
      p_sum[p_n]  = sv;
      p_wqm[p_n]  = (sv > ref_qm[cur]);
      ref_q[idx]  = sv;
      if (sv > ref_qm[cur]) ref_qm[cur] = sv;
      cur = nxt;
      p_n++;
    end
    p_final = cur;
  endtask

  // Drives one planned episode, acting as the pipeline, and checks it step by step.
  task automatic run_episode(input logic [5:0] st, input logic [5:0] en, input int delay);
    int k = 0, kk = 0, km = 0, wait_c = 0, cyc = 0, prev = 0;
    int qw = 0, qmw = 0, exp_qmw = 0, exp_done = 1;
    bit in_calc = 0, seen = 0;
    for (int i = 0; i < p_n; i++) begin
      if (p_wqm[i]) exp_qmw++;
      exp_done += (p_wqm[i] ? 8 : 7) + delay;
    end
    if (p_n > 0) action = p_a[0];
    start = 1'b1; start_state = st; end_state = en;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc < 300) begin
      cyc++;
      if (done) begin
        seen = 1;
        start = 1'b0; calc_done = 1'b0;
        n_cmp++; if (step_cnt !== 16'(p_n)) begin n_err++; $display("FAIL step_cnt: got %0d expected %0d", step_cnt, p_n); end
        n_cmp++; if (state_o !== p_final) begin n_err++; $display("FAIL final_state: got %0d expected %0d", state_o, p_final); end
        n_cmp++; if (k !== p_n) begin n_err++; $display("FAIL steps_run: got %0d expected %0d", k, p_n); end
        n_cmp++; if (qw !== p_n || qmw !== exp_qmw) begin n_err++; $display("FAIL write_count: got q=%0d qm=%0d expected q=%0d qm=%0d", qw, qmw, p_n, exp_qmw); end
        n_cmp++; if (cyc !== exp_done) begin n_err++; $display("FAIL done_cycle: got %0d expected %0d", cyc, exp_done); end
      end else begin
        if (!calc_valid && in_calc) begin in_calc = 0; k++; end
        if (calc_valid) begin
          if (!in_calc) begin
            in_calc = 1; wait_c = 0;
            kk = (k < MAXS) ? k : MAXS - 1;
            n_cmp++;
            if (k >= p_n) begin n_err++; $display("FAIL extra_step: got step %0d expected %0d steps", k, p_n); end
            else if ({op_q, op_r, op_qmax, state_o} !== {p_q[kk], p_r[kk], p_qmax[kk], p_s[kk]})
              begin n_err++; $display("FAIL operands: got q=%0d r=%0d qmax=%0d s=%0d expected q=%0d r=%0d qmax=%0d s=%0d",
                op_q, op_r, op_qmax, state_o, p_q[kk], p_r[kk], p_qmax[kk], p_s[kk]); end
            if (k > 0 && k <= p_n) begin
              n_cmp++;
              if (cyc - prev !== (p_wqm[k-1] ? 8 : 7) + delay) begin n_err++;
                $display("FAIL step_period: got %0d expected %0d", cyc - prev, (p_wqm[k-1] ? 8 : 7) + delay); end
            end
            prev = cyc;
            if (k + 1 < p_n) action = p_a[k+1];
          end
          if (wait_c == delay) begin calc_done = 1'b1; sum = p_sum[kk]; end
          else begin calc_done = 1'b0; sum = 8'($urandom); end
          wait_c++;
        end else begin
          calc_done = 1'($urandom); sum = 8'($urandom);
        end
        km = (k > 0 && k <= MAXS) ? k - 1 : 0;
        if (q_we) begin
          qw++;
          n_cmp++; if ({q_addr, q_wdata} !== {p_s[km], p_a[km], p_sum[km]}) begin n_err++;
            $display("FAIL q_write: got addr=%0h data=%0d expected addr=%0h data=%0d", q_addr, q_wdata, {p_s[km], p_a[km]}, p_sum[km]); end
        end
        if (qm_we) begin
          qmw++;
          n_cmp++; if ({qm_addr, qm_wdata} !== {p_s[km], p_sum[km]}) begin n_err++;
            $display("FAIL qm_write: got addr=%0d data=%0d expected addr=%0d data=%0d", qm_addr, qm_wdata, p_s[km], p_sum[km]); end
        end
        start = 1'($urandom); start_state = 6'($urandom); end_state = 6'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0; calc_done = 1'b0;
    if (!seen) begin n_cmp++; n_err++; $display("FAIL episode_timeout: got no done expected done within 300 cycles"); end
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL after_done: got busy=%0b done=%0b expected 0 0", busy, done); end
    n_cmp++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL table_contents: got %0d differing entries expected 0", mem_diffs()); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if ({busy, done, q_we, qm_we, calc_valid} !== 5'b0) begin n_err++;
        $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, q_we, qm_we, calc_valid}); end
      @(negedge clk);
    end
    n_cmp++;
    if ({q_addr, qm_addr, sa_addr, state_o, step_cnt, op_q, op_r, op_qmax, q_wdata, qm_wdata} !== '0) begin n_err++;
      $display("FAIL reset_data: got addr=%0h/%0h/%0h s=%0d cnt=%0d expected all 0", q_addr, qm_addr, sa_addr, state_o, step_cnt); end
  endtask

  task automatic test_zero_step();
    plan_episode(6'd3, 6'd3, -1, -1);
    run_episode(6'd3, 6'd3, 0);
  endtask

  task automatic setup_directed();
    ref_q[8'h01] = 8'd2; ref_qm[0] = 8'd4; ref_qm[7] = 8'd9;
    r_rom[8'h01] = 8'd5; ns_rom[8'h01] = 6'd7; ns_rom[{6'd7, 2'd1}] = 6'd12;
    load_tables();
  endtask

  task automatic test_qmax_write();
    setup_directed();
    plan_episode(6'd0, 6'd12, 6, 1);
    run_episode(6'd0, 6'd12, 0);
    n_cmp++; if ({q_mem[1], qm_mem[0], qm_mem[7]} !== {8'd6, 8'd6, 8'd9}) begin n_err++;
      $display("FAIL qmax_write: got Q=%0d Qmax0=%0d Qmax7=%0d expected 6 6 9", q_mem[1], qm_mem[0], qm_mem[7]); end
  endtask

  task automatic test_qmax_skip();
    setup_directed();
    plan_episode(6'd0, 6'd12, 4, 1);
    run_episode(6'd0, 6'd12, 0);
    n_cmp++; if ({q_mem[1], qm_mem[0]} !== {8'd4, 8'd4}) begin n_err++;
      $display("FAIL qmax_skip: got Q=%0d Qmax0=%0d expected 4 4", q_mem[1], qm_mem[0]); end
  endtask

  task automatic test_self_loop();
    for (int i = 0; i < 4; i++) ns_rom[{6'd10, 2'(i)}] = 6'd10;
    plan_episode(6'd10, 6'd20, -1, -1);
    run_episode(6'd10, 6'd20, int'($urandom_range(0, 2)));
    n_cmp++; if (step_cnt !== 16'd5) begin n_err++; $display("FAIL self_loop_steps: got %0d expected 5", step_cnt); end
  endtask

  task automatic test_random();
    logic [5:0] st, en;
    for (int e = 0; e < 12; e++) begin
      st = 6'($urandom);
      if (e % 3 == 0) begin
        en = ns_rom[{st, 2'd0}];
        plan_episode(st, en, -1, 0);
      end else begin
        en = 6'($urandom);
        plan_episode(st, en, -1, -1);
      end
      run_episode(st, en, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic wait_calc(output bit ok);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (calc_valid) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic test_abort_calc();
    bit ok;
    action = 2'd2; start = 1'b1; start_state = 6'd5; end_state = 6'd6;
    @(negedge clk) start = 1'b0;
    wait_calc(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_calc_reach: got no calc_valid expected calc_valid"); end
    for (int i = 0; i < 10; i++) begin
      calc_done = 1'b0;
      n_cmp++; if ({calc_valid, q_we, qm_we, done} !== 4'b1000) begin n_err++;
        $display("FAIL calc_hold: got %b expected 1000", {calc_valid, q_we, qm_we, done}); end
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({busy, done, calc_valid, q_we, qm_we} !== 5'b0) begin n_err++;
        $display("FAIL abort_calc_idle: got %b expected 00000", {busy, done, calc_valid, q_we, qm_we}); end
      @(negedge clk);
    end
    n_cmp++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL abort_calc_tables: got %0d differing entries expected 0", mem_diffs()); end
  endtask

  task automatic test_abort_write();
    bit ok;
    action = 2'd3; start = 1'b1; start_state = 6'd5; end_state = 6'd6;
    @(negedge clk) start = 1'b0;
    wait_calc(ok);
    calc_done = 1'b1; sum = ~ref_q[{6'd5, 2'd3}];
    @(negedge clk) calc_done = 1'b0;
    n_cmp++; if (q_we !== 1'b1) begin n_err++; $display("FAIL wr_q_enable: got %0b expected 1", q_we); end
    abort = 1'b1;
    #1;
    n_cmp++; if (q_we !== 1'b0) begin n_err++; $display("FAIL abort_we_gate: got %0b expected 0", q_we); end
    @(negedge clk) abort = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL abort_write_idle: got busy=%0b done=%0b expected 0 0", busy, done); end
    n_cmp++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL abort_write_tables: got %0d differing entries expected 0", mem_diffs()); end
  endtask

  task automatic test_reset_mid();
    action = 2'd1; start = 1'b1; start_state = 6'd8; end_state = 6'd9;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    n_cmp++;
    if ({busy, done, calc_valid, q_addr, qm_addr, sa_addr, state_o, step_cnt, op_q, op_r, op_qmax} !== '0) begin n_err++;
      $display("FAIL reset_mid: got busy=%0b addr=%0h/%0h/%0h s=%0d expected all 0", busy, q_addr, qm_addr, sa_addr, state_o); end
    n_cmp++; if (mem_diffs() !== 0) begin n_err++; $display("FAIL reset_mid_tables: got %0d differing entries expected 0", mem_diffs()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; calc_done = 1'b0; load_mem = 1'b0;
    start_state = '0; end_state = '0; action = '0; sum = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    init_tables();
    test_zero_step();
    test_qmax_write();
    test_qmax_skip();
    test_self_loop();
    test_random();
    test_abort_calc();
    test_abort_write();
    test_reset_mid();
    plan_episode(6'd0, 6'd1, -1, -1);
    run_episode(6'd0, 6'd1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
